// File: rtl/evt_enc16to4_pkg.sv
// Shared constants and FSM state type for the 16-to-4 event encoder.
package evt_enc16to4_pkg;

    localparam int ENC_N   = 16;
    localparam int ENC_IDW = 4;

    // IDLE: nothing presented; HOLD: id_o/id_valid presented to the consumer.
    typedef enum logic {
        S_IDLE = 1'b0,
        S_HOLD = 1'b1
    } state_t;

endpackage

// File: rtl/pick_first16.sv
// Combinational wrap-around search: first set bit of vec at or above start,
// wrapping 15->0. A start of 0 gives plain lowest-index priority.
module pick_first16
    import evt_enc16to4_pkg::*;
(
    input  logic [ENC_N-1:0]   vec,
    input  logic [ENC_IDW-1:0] start,
    output logic [ENC_IDW-1:0] idx,
    output logic               found,
    output logic [ENC_N-1:0]   onehot
);

    // vec rotated so that bit `start` lands at position 0.
    logic [ENC_N-1:0]   rot;
    logic [ENC_IDW-1:0] offset;

    for (genvar gi = 0; gi < ENC_N; gi++) begin : g_rot
        assign rot[gi] = vec[ENC_IDW'(gi) + start];
    end

    // Lowest set bit of the rotated vector is the first hit at/after start.
    always_comb begin
        offset = '0;
        found  = 1'b0;
        for (int i = ENC_N - 1; i >= 0; i--) begin
            if (rot[i]) begin
                offset = ENC_IDW'(i);
                found  = 1'b1;
            end
        end
    end

    assign idx = offset + start;

    // One-hot form of the chosen index, empty when nothing is set.
    for (genvar gi = 0; gi < ENC_N; gi++) begin : g_onehot
        assign onehot[gi] = found && (idx == ENC_IDW'(gi));
    end

endmodule

// File: rtl/evt_enc16to4.sv
// Sequential 16-to-4 event encoder: latches request lines into a pending
// register and drains them one ID per handshake, fixed-priority or round-robin.
module evt_enc16to4
    import evt_enc16to4_pkg::*;
#(
    parameter int RR_MODE = 0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               e,
    input  logic [ENC_N-1:0]   req,
    input  logic               clr_all,
    input  logic               id_ready,
    output logic [ENC_IDW-1:0] id_o,
    output logic               id_valid,
    output logic [ENC_N-1:0]   pend_o,
    output logic               overflow
);

    state_t             state_reg,  state_next;
    logic [ENC_N-1:0]   pend_reg,   pend_next;
    logic [ENC_IDW-1:0] id_reg,     id_next;
    logic               valid_reg,  valid_next;
    logic [ENC_IDW-1:0] rr_ptr_reg, rr_ptr_next;
    logic               ovf_reg,    ovf_next;

    logic [ENC_IDW-1:0] pick_start;
    logic [ENC_IDW-1:0] pick_idx;
    logic               pick_found;
    logic [ENC_N-1:0]   pick_onehot;
    logic               load;
    logic [ENC_N-1:0]   take_mask;
    logic [ENC_N-1:0]   req_gated;

    assign pick_start = (RR_MODE != 0) ? rr_ptr_reg : '0;
    assign req_gated  = req & {ENC_N{e}};

    pick_first16 u_pick (
        .vec    (pend_reg),
        .start  (pick_start),
        .idx    (pick_idx),
        .found  (pick_found),
        .onehot (pick_onehot)
    );

    // Next-state: FSM, pending update, round-robin pointer and overflow flag.
    always_comb begin
        state_next  = state_reg;
        id_next     = id_reg;
        valid_next  = valid_reg;
        rr_ptr_next = rr_ptr_reg;
        load        = 1'b0;

        unique case (state_reg)
            S_IDLE: begin
                if (pick_found) begin
                    load = 1'b1;
                end
            end
            S_HOLD: begin
                if (id_ready) begin
                    if (pick_found) begin
                        load = 1'b1;
                    end else begin
                        valid_next = 1'b0;
                        state_next = S_IDLE;
                    end
                end
            end
            default: state_next = S_IDLE;
        endcase

        if (load) begin
            id_next     = pick_idx;
            valid_next  = 1'b1;
            state_next  = S_HOLD;
            rr_ptr_next = pick_idx + ENC_IDW'(1);
        end

        take_mask = load ? pick_onehot : '0;
        pend_next = (pend_reg & ~take_mask) | req_gated;
        // A req landing on the bit being taken this cycle is a fresh event.
        ovf_next  = |(req_gated & pend_reg & ~take_mask);

        // Flush wins over everything; the round-robin position survives it.
        if (clr_all) begin
            pend_next   = '0;
            valid_next  = 1'b0;
            state_next  = S_IDLE;
            ovf_next    = 1'b0;
            id_next     = id_reg;
            rr_ptr_next = rr_ptr_reg;
        end
    end

    // State and output registers, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= S_IDLE;
            pend_reg   <= '0;
            id_reg     <= '0;
            valid_reg  <= 1'b0;
            rr_ptr_reg <= '0;
            ovf_reg    <= 1'b0;
        end else begin
            state_reg  <= state_next;
            pend_reg   <= pend_next;
            id_reg     <= id_next;
            valid_reg  <= valid_next;
            rr_ptr_reg <= rr_ptr_next;
            ovf_reg    <= ovf_next;
        end
    end

    assign id_o     = id_reg;
    assign id_valid = valid_reg;
    assign pend_o   = pend_reg;
    assign overflow = ovf_reg;

endmodule

// File: tb/tb_evt_enc16to4.sv
// Bench for evt_enc16to4: fixed-priority and round-robin instances share the
// stimulus and are checked against a per-instance behavioural model.
module tb_evt_enc16to4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        e = 1'b1;
    logic [15:0] req = '0;
    logic        clr_all = 1'b0;
    logic        id_ready = 1'b1;

    logic [3:0]  id_o0, id_o1;
    logic        v0, v1, o0, o1;
    logic [15:0] p0, p1;

    logic [3:0]  d_id [2];
    logic        d_valid [2];
    logic [15:0] d_pend [2];
    logic        d_ovf [2];

    assign d_id[0] = id_o0;  assign d_id[1] = id_o1;
    assign d_valid[0] = v0;  assign d_valid[1] = v1;
    assign d_pend[0] = p0;   assign d_pend[1] = p1;
    assign d_ovf[0] = o0;    assign d_ovf[1] = o1;

    evt_enc16to4 #(.RR_MODE(0)) u_fp (
        .clk(clk), .rst_n(rst_n), .e(e), .req(req), .clr_all(clr_all),
        .id_ready(id_ready), .id_o(id_o0), .id_valid(v0), .pend_o(p0), .overflow(o0)
    );

    evt_enc16to4 #(.RR_MODE(1)) u_rr (
        .clk(clk), .rst_n(rst_n), .e(e), .req(req), .clr_all(clr_all),
        .id_ready(id_ready), .id_o(id_o1), .id_valid(v1), .pend_o(p1), .overflow(o1)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;

    // Reference model: set of pending events, the ID on offer, rr position.
    logic [15:0] m_pend [2];
    logic [3:0]  m_id [2];
    logic        m_valid [2];
    logic        m_ovf [2];
    int          m_rr [2];

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_pend[k] = '0; m_id[k] = '0; m_valid[k] = 1'b0; m_ovf[k] = 1'b0; m_rr[k] = 0;
        end
    endtask

    // First pending event scanning upward from the start point, with wrap.
    function automatic int pick(input int k);
        int start;
        start = (k == 1) ? m_rr[k] : 0;
        for (int off = 0; off < 16; off++) begin
            if (m_pend[k][(start + off) % 16]) return (start + off) % 16;
        end
        return -1;
    endfunction

    task automatic model_step();
        logic [15:0] newreq, kept;
        int p;
        for (int k = 0; k < 2; k++) begin
            newreq = e ? req : 16'h0;
            kept = m_pend[k];
            p = -1;
            if (m_pend[k] != 0 && (!m_valid[k] || id_ready)) p = pick(k);
            if (p >= 0) kept[p] = 1'b0;
            if (clr_all) begin
                m_pend[k] = '0; m_valid[k] = 1'b0; m_ovf[k] = 1'b0;
            end else begin
                m_ovf[k] = (newreq & kept) != 0;
                if (p >= 0) begin
                    m_id[k] = 4'(p); m_valid[k] = 1'b1; m_rr[k] = (p + 1) % 16;
                end else if (m_valid[k] && id_ready) begin
                    m_valid[k] = 1'b0;
                end
                m_pend[k] = kept | newreq;
            end
        end
    endtask

    // Advance one clock: model follows the edge, outputs settle 1 time unit later.
    task automatic tick();
        @(posedge clk);
        model_step();
        cyc++;
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req = 16'h0005; e = 1'b1; id_ready = 1'b1; clr_all = 1'b0;
        model_reset();
        #3;
        n_cmp++;
        if ({id_o0, v0, p0, o0, id_o1, v1, p1, o1} !== 42'h0) begin
            n_bad++;
            $display("FAIL reset_values: got id=%0d v=%0b pend=%h ovf=%0b, want all 0", id_o0, v0, p0, o0);
        end
        @(negedge clk); rst_n = 1'b1;
        for (int t = 0; t < 5; t++) begin
            tick();
            if (t == 0) req = 16'h0000;
            for (int k = 0; k < 2; k++) begin
                n_cmp++;
                if (d_valid[k] !== m_valid[k] || d_pend[k] !== m_pend[k] || d_ovf[k] !== m_ovf[k] ||
                    (m_valid[k] && d_id[k] !== m_id[k])) begin
                    n_bad++;
                    $display("FAIL reset_drain inst%0d cyc%0d: got id=%0d v=%0b pend=%h ovf=%0b, want id=%0d v=%0b pend=%h ovf=%0b",
                             k, cyc, d_id[k], d_valid[k], d_pend[k], d_ovf[k], m_id[k], m_valid[k], m_pend[k], m_ovf[k]);
                end
            end
            // Fixed priority: ID 0 on the 2nd edge, ID 2 on the 3rd, then idle.
            n_cmp++;
            if ((t == 1 && {v0, id_o0} !== 5'h10) || (t == 2 && {v0, id_o0} !== 5'h12) ||
                (t >= 3 && {v0, p0} !== 17'h0)) begin
                n_bad++;
                $display("FAIL reset_sequence t=%0d: got v=%0b id=%0d pend=%h", t, v0, id_o0, p0);
            end
        end
    endtask

    task automatic test_hold();
        req = 16'h8001; id_ready = 1'b0;
        tick();
        req = 16'h0000;
        for (int t = 0; t < 7; t++) begin
            if (t == 6) id_ready = 1'b1;
            tick();
            for (int k = 0; k < 2; k++) begin
                n_cmp++;
                if (d_valid[k] !== m_valid[k] || d_pend[k] !== m_pend[k] || d_ovf[k] !== m_ovf[k] ||
                    (m_valid[k] && d_id[k] !== m_id[k])) begin
                    n_bad++;
                    $display("FAIL hold inst%0d cyc%0d: got id=%0d v=%0b pend=%h, want id=%0d v=%0b pend=%h",
                             k, cyc, d_id[k], d_valid[k], d_pend[k], m_id[k], m_valid[k], m_pend[k]);
                end
            end
            n_cmp++;
            if ((t < 6 && {v0, id_o0} !== 5'h10) || (t == 6 && {v0, id_o0} !== 5'h1F)) begin
                n_bad++;
                $display("FAIL hold_stable t=%0d: got v=%0b id=%0d, want v=1 id=%0d", t, v0, id_o0, (t < 6) ? 0 : 15);
            end
        end
        repeat (2) tick();
    endtask

    task automatic test_round_robin();
        rst_n = 1'b0; model_reset(); req = 16'h0000; id_ready = 1'b1;
        #2 rst_n = 1'b1;
        req = 16'hFFFF;
        for (int t = 0; t < 20; t++) begin
            tick();
            for (int k = 0; k < 2; k++) begin
                n_cmp++;
                if (d_valid[k] !== m_valid[k] || d_pend[k] !== m_pend[k] || d_ovf[k] !== m_ovf[k] ||
                    (m_valid[k] && d_id[k] !== m_id[k])) begin
                    n_bad++;
                    $display("FAIL rr inst%0d cyc%0d: got id=%0d v=%0b pend=%h ovf=%0b, want id=%0d v=%0b pend=%h ovf=%0b",
                             k, cyc, d_id[k], d_valid[k], d_pend[k], d_ovf[k], m_id[k], m_valid[k], m_pend[k], m_ovf[k]);
                end
            end
            if (t >= 1) begin
                n_cmp++;
                if (v1 !== 1'b1 || id_o1 !== 4'((t - 1) % 16)) begin
                    n_bad++;
                    $display("FAIL rr_sequence t=%0d: got v=%0b id=%0d, want v=1 id=%0d", t, v1, id_o1, (t - 1) % 16);
                end
            end
        end
        req = 16'h0000;
        repeat (18) tick();
    endtask

    task automatic test_overflow();
        int ovf_seen = 0;
        int id3_seen = 0;
        id_ready = 1'b0;
        for (int t = 0; t < 10; t++) begin
            req = (t == 0) ? 16'h0009 : (t == 2) ? 16'h0008 : 16'h0000;
            if (t == 6) id_ready = 1'b1;
            tick();
            for (int k = 0; k < 2; k++) begin
                n_cmp++;
                if (d_valid[k] !== m_valid[k] || d_pend[k] !== m_pend[k] || d_ovf[k] !== m_ovf[k] ||
                    (m_valid[k] && d_id[k] !== m_id[k])) begin
                    n_bad++;
                    $display("FAIL overflow inst%0d cyc%0d: got id=%0d v=%0b pend=%h ovf=%0b, want id=%0d v=%0b pend=%h ovf=%0b",
                             k, cyc, d_id[k], d_valid[k], d_pend[k], d_ovf[k], m_id[k], m_valid[k], m_pend[k], m_ovf[k]);
                end
            end
            if (o0) ovf_seen++;
            if (t >= 6 && v0 && id_o0 == 4'd3) id3_seen++;
        end
        n_cmp++;
        if (ovf_seen != 1 || id3_seen != 1) begin
            n_bad++;
            $display("FAIL overflow_count: got ovf_cycles=%0d id3=%0d, want 1 and 1", ovf_seen, id3_seen);
        end
    endtask

    task automatic test_enable();
        e = 1'b0; req = 16'h00F0;
        repeat (3) tick();
        n_cmp++;
        if (v0 !== 1'b0 || p0 !== 16'h0 || v1 !== 1'b0 || p1 !== 16'h0) begin
            n_bad++;
            $display("FAIL enable_drop: got v=%0b pend=%h, want v=0 pend=0000", v0, p0);
        end
        e = 1'b1; req = 16'h0100;
        tick();
        e = 1'b0; req = 16'hFFFF;
        for (int t = 0; t < 3; t++) begin
            tick();
            for (int k = 0; k < 2; k++) begin
                n_cmp++;
                if (d_valid[k] !== m_valid[k] || d_pend[k] !== m_pend[k] || d_ovf[k] !== m_ovf[k] ||
                    (m_valid[k] && d_id[k] !== m_id[k])) begin
                    n_bad++;
                    $display("FAIL enable inst%0d cyc%0d: got id=%0d v=%0b pend=%h, want id=%0d v=%0b pend=%h",
                             k, cyc, d_id[k], d_valid[k], d_pend[k], m_id[k], m_valid[k], m_pend[k]);
                end
            end
            n_cmp++;
            if (t == 0 && ({v0, id_o0} !== 5'h18 || {v1, id_o1} !== 5'h18)) begin
                n_bad++;
                $display("FAIL enable_drain: got v=%0b id=%0d, want v=1 id=8", v0, id_o0);
            end
        end
        e = 1'b1; req = 16'h0000;
    endtask

    task automatic test_clear_and_async_reset();
        id_ready = 1'b0; req = 16'h0003;
        repeat (2) tick();
        clr_all = 1'b1; req = 16'h0001; id_ready = 1'b1;
        tick();
        clr_all = 1'b0; req = 16'h0000;
        n_cmp++;
        if (v0 !== 1'b0 || p0 !== 16'h0 || v1 !== 1'b0 || p1 !== 16'h0 || o0 !== 1'b0) begin
            n_bad++;
            $display("FAIL clear: got v=%0b pend=%h ovf=%0b, want v=0 pend=0000 ovf=0", v0, p0, o0);
        end
        id_ready = 1'b0; req = 16'h0010;
        repeat (3) tick();
        n_cmp++;
        if (v0 !== 1'b1 || id_o0 !== 4'd4) begin
            n_bad++;
            $display("FAIL pre_reset_hold: got v=%0b id=%0d, want v=1 id=4", v0, id_o0);
        end
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        n_cmp++;
        if ({id_o0, v0, p0, o0, id_o1, v1, p1, o1} !== 42'h0) begin
            n_bad++;
            $display("FAIL async_reset: got id=%0d v=%0b pend=%h ovf=%0b, want all 0", id_o0, v0, p0, o0);
        end
        req = 16'h0000; id_ready = 1'b1;
        @(negedge clk); rst_n = 1'b1;
    endtask

    task automatic test_random();
        for (int t = 0; t < 400; t++) begin
            req = 16'($urandom) & 16'($urandom) & 16'($urandom);
            e = ($urandom_range(0, 3) != 0);
            id_ready = ($urandom_range(0, 2) != 0);
            clr_all = ($urandom_range(0, 24) == 0);
            tick();
            for (int k = 0; k < 2; k++) begin
                n_cmp++;
                if (d_valid[k] !== m_valid[k] || d_pend[k] !== m_pend[k] || d_ovf[k] !== m_ovf[k] ||
                    (m_valid[k] && d_id[k] !== m_id[k])) begin
                    n_bad++;
                    $display("FAIL random inst%0d cyc%0d: got id=%0d v=%0b pend=%h ovf=%0b, want id=%0d v=%0b pend=%h ovf=%0b",
                             k, cyc, d_id[k], d_valid[k], d_pend[k], d_ovf[k], m_id[k], m_valid[k], m_pend[k], m_ovf[k]);
                end
            end
        end
        clr_all = 1'b0;
    endtask

    initial begin
        test_reset();
        test_hold();
        test_round_robin();
        test_overflow();
        test_enable();
        test_clear_and_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
